ifetch_prefetch: RTL and testbench
==================================

// Module: ifetch_prefetch
// PURPOSE
//  Instruction-fetch stage between the instruction ROM and the core's decode stage.
//  Owns the fetch PC and issues sequential ROM reads.
//  Buffers returned words in a small FIFO and presents {inst, pc} to decode over a valid/ready handshake.
//  On a taken jump/branch it flushes all buffered and in-flight fetches and restarts at the target.
// PARAMETERS
//  DEPTH     4             FIFO entries; power of two, >= 2
//  RESET_PC  32'h0000_0000 fetch address after reset
//  XLEN      32            address/instruction width
// PORTS
//  clk           in   1     clock, all state on rising edge
//  rst           in   1     synchronous reset, active-high
//  rom_req_o     out  1     ROM read strobe this cycle
//  rom_addr_o    out  XLEN  byte address of read; bits[1:0] always 0
//  rom_data_i    in   XLEN  ROM word; valid exactly 1 cycle after rom_req_o
//  jump_en_i     in   1     redirect request from execute (1-cycle pulse)
//  jump_addr_i   in   XLEN  redirect target
//  inst_valid_o  out  1     FIFO head holds a valid instruction
//  inst_ready_i  in   1     decode accepts head this cycle
//  inst_o        out  XLEN  instruction at head; NOP when not valid
//  inst_addr_o   out  XLEN  PC of inst_o; 0 when not valid
//  level_o       out  $clog2(DEPTH)+1  entries currently buffered
// BEHAVIOUR
//  Reset (rst=1 at an edge): fetch_pc<=RESET_PC, FIFO empty, inflight<=0, discard<=0.
//    Outputs: rom_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0, level_o=0.
//    Reset overrides jump and pop in the same cycle.
//  Credit rule:
//    rom_req_o = !rst && (level + inflight - pop) < DEPTH.
//    inflight = a request was issued last cycle; its response is not yet pushed.
//    A simultaneous pop frees a slot in the same cycle.
//    No request may overflow the FIFO, so no FIFO write is ever dropped.
//  Sequential fetch: rom_addr_o=fetch_pc. On each issued request fetch_pc<=fetch_pc+4.
//    The addition wraps 32'hFFFF_FFFC -> 0.
//    Each request records its address in a 1-deep pc_pipe register for pairing with the response.
//  Response: the cycle after a request, {rom_data_i, pc_pipe} is pushed unless discard=1.
//    Issue-to-inst_valid_o latency = 2 cycles (ROM cycle, FIFO write), i.e. registered head.
//  Handshake: head pops iff inst_valid_o && inst_ready_i.
//    inst_o/inst_addr_o hold stable while valid && !ready.
//    Push and pop may occur in the same cycle, including at full and at empty (level unchanged).
//  Jump (jump_en_i=1, not in reset):
//    - FIFO cleared at the edge; level_o=0 next cycle; any pop that cycle is ignored.
//    - A response arriving next cycle (from this or the previous cycle's request) is discarded.
//      To do this, the jump-cycle request is suppressed and discard<=inflight.
//    - fetch_pc <= {jump_addr_i[31:2],2'b00}; first redirected request is issued the cycle after the jump.
//    - Jump-to-first-valid latency = 3 cycles.
//    - Back-to-back jumps: the last one wins.
//  Misaligned target: bits[1:0] are silently cleared; no trap is raised here.
//  When empty: inst_valid_o=0, inst_o=32'h0000_0013 (NOP), inst_addr_o=0.
// STRUCTURE
//  Package riscv_defs_pkg: XLEN, INST_NOP=32'h0000_0013, RESET_PC default.
//  Sub-module sync_fifo (WIDTH=2*XLEN, DEPTH):
//    - ports clk, rst, clr, push, din, pop, dout, empty, full, level
//    - circular pointers one bit wider than the index; full = MSBs differ and indices equal
//    - clr has the same effect as rst
//  Top level: fetch_pc, pc_pipe, inflight, discard, credit logic, output muxing to NOP.
// TESTING
//  T1 reset: hold rst 3 cycles, release with ready=1 ->
//     rom_req_o high on the 1st post-reset cycle with addr 0.
//     inst_valid_o rises 2 cycles later with inst_addr_o=0 and inst_o=rom[0].
//  T2 streaming: ready=1 constant -> one instruction per cycle, addresses 0,4,8,... with no gaps.
//     rom_req_o stays high every cycle.
//  T3 backpressure: ready=0 for 10 cycles ->
//     level_o saturates at DEPTH (4) and rom_req_o falls; no entry is lost.
//     On ready=1 the sequence resumes at the next address without duplication.
//  T4 jump flush: jump_en_i=1, jump_addr_i=32'h100 while streaming ->
//     level_o=0 next cycle; no pre-jump PC ever appears after the jump.
//     First valid output has inst_addr_o=32'h100, 3 cycles after the jump; then 32'h104.
//  T5 corner cases: jump while full with ready=1 in the same cycle, and jump_addr_i=32'h203 ->
//     the pop is ignored and the next valid output is at 32'h200.
//     Also: a fetch from 32'hFFFF_FFFC is followed by a fetch from 0.
//  T6 mid-operation reset: assert rst with the FIFO half full and a request in flight ->
//     next cycle inst_valid_o=0 and level_o=0.
//     After release, the first output has inst_addr_o=RESET_PC; no stale word leaks through.
//  All tests: scoreboard checks inst_o == rom[inst_addr_o>>2] on every accepted beat.

Source files
------------

// File: rtl/riscv_defs_pkg.sv
// Shared RISC-V core constants.
// Fetch width, canonical NOP and default reset vector.
package riscv_defs_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// clr empties the FIFO exactly like rst.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
  assign dout  = mem[rp[AW-1:0]];
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + (AW+1)'(1);
      if (rd_en) rp <= rp + (AW+1)'(1);
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !(rst || clr))
      mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction fetch with credit-limited ROM prefetch.
// Buffers {inst, pc} for decode; flushes on redirect.
module ifetch_prefetch #(
  parameter int XLEN  = riscv_defs_pkg::XLEN,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC =
    XLEN'(riscv_defs_pkg::RESET_PC_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      rom_req_o,
  output logic [XLEN-1:0]           rom_addr_o,
  input  logic [XLEN-1:0]           rom_data_i,
  input  logic                      jump_en_i,
  input  logic [XLEN-1:0]           jump_addr_i,
  output logic                      inst_valid_o,
  input  logic                      inst_ready_i,
  output logic [XLEN-1:0]           inst_o,
  output logic [XLEN-1:0]           inst_addr_o,
  output logic [$clog2(DEPTH):0]    level_o
);
  import riscv_defs_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   pc_pipe;
  logic              inflight;
  logic              discard;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [LW-1:0]     level;
  logic [LW:0]       need;
  logic [2*XLEN-1:0] head;

  assign pop  = !empty && inst_ready_i && !jump_en_i;
  assign push = inflight && !discard;

  // Slots already promised to in-flight words count against capacity.
  assign need = {1'b0, level}
              + {{LW{1'b0}}, inflight}
              - {{LW{1'b0}}, pop};

  assign rom_req_o = !rst && !jump_en_i &&
                     !(full && !pop) &&
                     (need < (LW+1)'(DEPTH));
  assign rom_addr_o = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pc_pipe  <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else if (jump_en_i) begin
      fetch_pc <= {jump_addr_i[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      discard  <= inflight;
    end else begin
      inflight <= rom_req_o;
      discard  <= 1'b0;
      if (rom_req_o) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pc_pipe  <= fetch_pc;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (jump_en_i),
    .push  (push),
    .din   ({rom_data_i, pc_pipe}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  assign inst_valid_o = !empty;
  assign inst_o       = empty ? XLEN'(INST_NOP)
                              : head[2*XLEN-1:XLEN];
  assign inst_addr_o  = empty ? '0 : head[XLEN-1:0];
  assign level_o      = level;
endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: directed scenarios plus random
// ready/jump traffic against an in-order PC stream model.
module tb_ifetch_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i = '0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [2:0]  level_o;

  int nvec = 0;
  int nerr = 0;
  int nacc = 0;
  logic [31:0] exp_pc = 32'h0;

  ifetch_prefetch #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .jump_en_i    (jump_en_i),
    .jump_addr_i  (jump_addr_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // ROM answers one cycle after a request; junk otherwise.
  always @(posedge clk)
    rom_data_i <= rom_req_o ? romw(rom_addr_o) : $urandom;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic j, input logic [31:0] ja,
                     input logic rdy, input logic r);
    logic        acc;
    logic [31:0] a_obs;
    logic [31:0] i_obs;
    jump_en_i    = j;
    jump_addr_i  = ja;
    inst_ready_i = rdy;
    rst          = r;
    #1;
    acc   = inst_valid_o && rdy && !j && !r;
    a_obs = inst_addr_o;
    i_obs = inst_o;
    @(posedge clk);
    if (acc) begin
      chk("beat_pc", a_obs, exp_pc);
      chk("beat_inst", i_obs, romw(exp_pc));
      exp_pc = exp_pc + 32'd4;
      nacc++;
    end
    if (r)      exp_pc = 32'h0;
    else if (j) exp_pc = {ja[31:2], 2'b00};
    @(negedge clk);
    if (!inst_valid_o) begin
      chk("idle_nop", inst_o, 32'h0000_0013);
      chk("idle_addr", inst_addr_o, 32'h0);
    end
    chk("level_bound", 32'(level_o <= 3'd4), 32'd1);
  endtask

  initial begin
    int base;
    @(negedge clk);
    // T1: reset, then first fetch
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      chk("rst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_req", 32'(rom_req_o), 32'd0);
    end
    rst = 1'b0;
    inst_ready_i = 1'b1;
    #1;
    chk("t1_req", 32'(rom_req_o), 32'd1);
    chk("t1_addr", rom_addr_o, 32'h0);
    chk("t1_valid0", 32'(inst_valid_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_valid1", 32'(inst_valid_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t1_valid2", 32'(inst_valid_o), 32'd1);
    chk("t1_pc", inst_addr_o, 32'h0);
    chk("t1_inst", inst_o, romw(32'h0));

    // T2: streaming without gaps
    for (int i = 0; i < 12; i++) begin
      chk("t2_req", 32'(rom_req_o), 32'd1);
      chk("t2_valid", 32'(inst_valid_o), 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
    end

    // T3: backpressure
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    inst_ready_i = 1'b0;
    #1;
    chk("t3_level", 32'(level_o), 32'd4);
    chk("t3_req", 32'(rom_req_o), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // T4: jump while streaming
    cyc(1'b1, 32'h100, 1'b1, 1'b0);
    chk("t4_level", 32'(level_o), 32'd0);
    chk("t4_valid1", 32'(inst_valid_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_valid2", 32'(inst_valid_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_valid3", 32'(inst_valid_o), 32'd1);
    chk("t4_pc", inst_addr_o, 32'h100);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t4_pc2", inst_addr_o, 32'h104);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // T5: jump while full with ready, misaligned target
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t5_full", 32'(level_o), 32'd4);
    cyc(1'b1, 32'h203, 1'b1, 1'b0);
    chk("t5_level", 32'(level_o), 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("t5_valid", 32'(inst_valid_o), 32'd1);
    chk("t5_pc", inst_addr_o, 32'h200);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // T5: address wrap
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
    chk("wrap_a0", rom_addr_o, 32'hFFFF_FFF8);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_a1", rom_addr_o, 32'hFFFF_FFFC);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap_a2", rom_addr_o, 32'h0);
    chk("wrap_req", 32'(rom_req_o), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Random ready and redirect traffic
    base = nacc;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 15) == 0), $urandom,
          ($urandom_range(0, 3) != 0), 1'b0);
    end
    chk("rand_progress", 32'((nacc - base) > 60), 32'd1);

    // T6: reset mid-operation
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    chk("t6_valid", 32'(inst_valid_o), 32'd0);
    chk("t6_level", 32'(level_o), 32'd0);
    for (int k = 0; k < 6 && !inst_valid_o; k++)
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_timeout", 32'(inst_valid_o), 32'd1);
    chk("t6_pc", inst_addr_o, 32'h0);
    chk("t6_inst", inst_o, romw(32'h0));
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
